// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with column scan, row debounce and a valid/ack key-code handshake.
// Define KEYPAD_OVERRUN_EN to add the sticky overrun_o flag for keys dropped while one is pending.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ack_i,
  output logic       key_pressed_o
`ifdef KEYPAD_OVERRUN_EN
  ,
  output logic       overrun_o
`endif
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntMax   = CntW'(DEBOUNCE_CNT);
  localparam bit DebOne = (DEBOUNCE_CNT == 1);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld
  } state_e;

  state_e            state_q;
  logic [3:0]        row_s1_q;
  logic [3:0]        row_s2_q;
  logic [PrescW-1:0] presc_q;
  logic [1:0]        col_q;
  logic [1:0]        row_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;
  logic              key_pressed_q;

  logic            tick;
  logic            any_low;
  logic [1:0]      sel_row;
  logic            same_row;
  logic [CntW-1:0] cnt_inc;
  logic            latch;
  logic [3:0]      new_code;

  always_comb begin
    tick    = (presc_q == PrescMax);
    any_low = (row_s2_q != 4'hF);
    // Lowest-index active row wins when several rows are low.
    if (!row_s2_q[0]) begin
      sel_row = 2'd0;
    end else if (!row_s2_q[1]) begin
      sel_row = 2'd1;
    end else if (!row_s2_q[2]) begin
      sel_row = 2'd2;
    end else begin
      sel_row = 2'd3;
    end
    same_row = any_low && (sel_row == row_q);
    cnt_inc  = cnt_q + CntW'(1);
    latch    = tick && (((state_q == StScan) && any_low && DebOne) ||
                        ((state_q == StDebounce) && same_row && (cnt_inc == CntMax)));
    new_code = {((state_q == StScan) ? sel_row : row_q), col_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StScan;
      row_s1_q      <= 4'hF;
      row_s2_q      <= 4'hF;
      presc_q       <= '0;
      col_q         <= 2'd0;
      row_q         <= 2'd0;
      cnt_q         <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
      presc_q  <= tick ? '0 : presc_q + PrescW'(1);
      if (tick) begin
        unique case (state_q)
          StScan: begin
            if (!any_low) begin
              col_q <= col_q + 2'd1;
            end else begin
              row_q <= sel_row;
              if (DebOne) begin
                cnt_q         <= '0;
                key_pressed_q <= 1'b1;
                state_q       <= StHeld;
              end else begin
                cnt_q   <= CntW'(1);
                state_q <= StDebounce;
              end
            end
          end
          StDebounce: begin
            if (same_row) begin
              if (cnt_inc == CntMax) begin
                cnt_q         <= '0;
                key_pressed_q <= 1'b1;
                state_q       <= StHeld;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              col_q   <= col_q + 2'd1;
              state_q <= StScan;
            end
          end
          StHeld: begin
            // cnt_q now counts consecutive all-released ticks.
            if (!any_low) begin
              if (cnt_inc == CntMax) begin
                cnt_q         <= '0;
                key_pressed_q <= 1'b0;
                col_q         <= col_q + 2'd1;
                state_q       <= StScan;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else if (!row_s2_q[row_q]) begin
              cnt_q <= '0;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

  // A fresh key replaces the pending one only if the slot is empty or being acked now.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else if (latch && (!key_valid_q || key_ack_i)) begin
      key_code_q  <= new_code;
      key_valid_q <= 1'b1;
    end else if (key_ack_i && key_valid_q) begin
      key_valid_q <= 1'b0;
    end
  end

`ifdef KEYPAD_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
    end else if (latch && key_valid_q && !key_ack_i) begin
      overrun_q <= 1'b1;
    end else if (key_ack_i && key_valid_q) begin
      overrun_q <= 1'b0;
    end
  end

  assign overrun_o = overrun_q;
`endif

  assign col_o         = ~(4'b0001 << col_q);
  assign key_code_o    = key_code_q;
  assign key_valid_o   = key_valid_q;
  assign key_pressed_o = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) with a keypad model.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_pressed;
`ifdef KEYPAD_OVERRUN_EN
  logic        overrun;
`endif

  logic [15:0] keys = 16'h0;
  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        prev_v = 1'b0;
  logic [3:0]  prev_c = 4'h0;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .row_i        (row),
    .col_o        (col),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_ack_i    (key_ack),
    .key_pressed_o(key_pressed)
`ifdef KEYPAD_OVERRUN_EN
    ,
    .overrun_o    (overrun)
`endif
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every newly presented code is compared against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (key_valid && (!prev_v || key_code != prev_c)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_key: got code %0h, expected none", key_code);
        end else begin
          check("key_code", {28'h0, key_code}, {28'h0, exp_q.pop_front()});
        end
      end
      prev_v = key_valid;
      prev_c = key_code;
    end
  end

  task automatic press(input int r, input int c, input bit push);
    keys[r*4+c] = 1'b1;
    if (push) exp_q.push_back(4'(r*4 + c));
  endtask

  // sel 0: key_valid, sel 1: key_pressed
  task automatic wait_sig(input int sel, input logic v, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (((sel == 0) ? key_valid : key_pressed) == v) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout, expected level %0b within %0d cycles", name, v, budget);
    end
  endtask

  // Returns just after the edge on which col_o switches to target.
  task automatic wait_col(input logic [3:0] target);
    bit done = 1'b0;
    for (int i = 0; i < 40 && col == target; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (col == target) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_col: got timeout, expected col_o %b", target);
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    #3;
    check("rst_col", {28'h0, col}, 32'hE);
    check("rst_code", {28'h0, key_code}, 32'h0);
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    check("rst_pressed", {31'h0, key_pressed}, 32'h0);
`ifdef KEYPAD_OVERRUN_EN
    check("rst_overrun", {31'h0, overrun}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Row2/col1 held: code 9, ack clears valid, code kept
    press(2, 1, 1'b1);
    wait_sig(0, 1'b1, 100, "valid_9");
    check("pressed_9", {31'h0, key_pressed}, 32'h1);
    ack_pulse();
    check("ack_valid_9", {31'h0, key_valid}, 32'h0);
    check("ack_code_9", {28'h0, key_code}, 32'h9);
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_9");

    // Key 6 left pending, then reset mid-debounce of key (0,0)
    press(1, 2, 1'b1);
    wait_sig(0, 1'b1, 100, "valid_6");
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_6");
    press(0, 0, 1'b0);
    wait_col(4'b1110);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_col", {28'h0, col}, 32'hE);
    check("midrst_valid", {31'h0, key_valid}, 32'h0);
    check("midrst_pressed", {31'h0, key_pressed}, 32'h0);
    keys = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 0 || k == 3 || k == 4 || k == 8 || k == 12 || k == 16) begin
        check($sformatf("colseq_%0d", k), {28'h0, col}, {28'h0, ~(4'b0001 << ((k / 4) % 4))});
      end
    end

    // Row0/col3 bounce: low one tick then released, scan must resume
    wait_col(4'b0111);
    press(0, 3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    keys = 16'h0;
    repeat (8) @(posedge clk);
    #1;
    check("bounce_valid", {31'h0, key_valid}, 32'h0);
    check("bounce_col", {28'h0, col}, 32'hD);
    press(0, 3, 1'b1);
    wait_sig(0, 1'b1, 100, "valid_3");
    ack_pulse();
    check("ack_valid_3", {31'h0, key_valid}, 32'h0);
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_3");

    // Rows 1 and 3 on col0: lowest row wins; release restarts scan at col1
    press(1, 0, 1'b1);
    press(3, 0, 1'b0);
    wait_sig(0, 1'b1, 100, "valid_4");
    check("pressed_4", {31'h0, key_pressed}, 32'h1);
    ack_pulse();
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_4");
    check("restart_col1", {28'h0, col}, 32'hD);

    // Key A (5) pending, key B (10) dropped
    press(1, 1, 1'b1);
    wait_sig(0, 1'b1, 100, "valid_5");
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_5");
    press(2, 2, 1'b0);
    wait_sig(1, 1'b1, 100, "pressed_10");
    check("drop_code", {28'h0, key_code}, 32'h5);
    check("drop_valid", {31'h0, key_valid}, 32'h1);
`ifdef KEYPAD_OVERRUN_EN
    check("drop_overrun", {31'h0, overrun}, 32'h1);
`endif
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_10");
`ifdef KEYPAD_OVERRUN_EN
    check("overrun_sticky", {31'h0, overrun}, 32'h1);
`endif
    ack_pulse();
    check("ack_valid_5", {31'h0, key_valid}, 32'h0);
`ifdef KEYPAD_OVERRUN_EN
    check("ack_overrun", {31'h0, overrun}, 32'h0);
`endif

    // Ack coincides with latch of code 2: new key wins
    press(1, 1, 1'b1);
    wait_sig(0, 1'b1, 100, "valid_5b");
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_5b");
    wait_col(4'b1011);
    press(0, 2, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    check("pre_latch_valid", {31'h0, key_valid}, 32'h1);
    ack_pulse();
    check("race_valid", {31'h0, key_valid}, 32'h1);
    check("race_code", {28'h0, key_code}, 32'h2);
    check("race_pressed", {31'h0, key_pressed}, 32'h1);
`ifdef KEYPAD_OVERRUN_EN
    check("race_overrun", {31'h0, overrun}, 32'h0);
`endif
    keys = 16'h0;
    wait_sig(1, 1'b0, 60, "release_2");
    ack_pulse();
    check("final_valid", {31'h0, key_valid}, 32'h0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and turns a debounced key press into a 4-bit key code with a valid/ack handshake.
- The CPU-facing side consumes the code as a memory-mapped input.
- It is the input-side counterpart of the multiplexed hex display: that block drives digits out, this block multiplexes matrix rows in.
- Runs on the board clock; it is clocked directly, not through a clkdivider instance.

Parameters:
- SCAN_DIV, 10000: clk cycles per scan tick (column dwell time); must be >= 3.
- DEBOUNCE_CNT, 4: consecutive matching ticks required for both press and release; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- row_in  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- col_out  out  4  column drive, active-low one-hot
- key_code  out  4  latched key, code = row_index*4 + col_index
- key_valid  out  1  new key available; held until acknowledged
- key_ack  in  1  consumer pulse; clears key_valid
- key_pressed  out  1  high while a debounced key is held
- overrun  out  1  present only with KEYPAD_OVERRUN_EN

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - col_out=4'b1110, key_code=0, key_valid=0, key_pressed=0, overrun=0.
  - State=SCAN, prescaler=0, column=0, debounce count=0.
  - Synchronizer flops preset to 4'b1111.
- row_in passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Prescaler counts 0..SCAN_DIV-1. tick=1 on the cycle it equals SCAN_DIV-1, then it wraps to 0.
- Row select: when several bits of rs are low, the lowest index wins.
- State SCAN:
  - col_out drives the current column low.
  - On tick with rs==4'hF: advance the column (3 wraps to 0); col_out updates the next cycle.
  - On tick with any rs bit low: lock the column, record the row, set count=1, go to DEBOUNCE.
- State DEBOUNCE:
  - Column stays frozen.
  - On tick with the same recorded row low: count++.
  - When count reaches DEBOUNCE_CNT (including DEBOUNCE_CNT=1, so on the entry tick): latch the code, go to HELD.
  - On tick with a different row or no row: count=0, advance the column, go to SCAN.
- State HELD:
  - key_pressed=1, column frozen.
  - On tick with rs==4'hF: release count++. On tick with the recorded row low: release count=0.
  - When release count reaches DEBOUNCE_CNT: key_pressed=0, advance the column, go to SCAN.
- Code latch: the cycle after the qualifying tick, key_valid=1 and key_code=new code.
- Handshake:
  - key_ack with key_valid=1 clears key_valid the next cycle. key_code keeps its value.
  - key_ack with key_valid=0 is ignored.
- Simultaneous new key latch and key_ack in one cycle: the new key wins. key_valid stays 1 and key_code takes the new code.
- New key latch while key_valid=1 and no ack: the new code is dropped. key_code and key_valid are unchanged.
- Latency: from a stable press on the scanned column, key_valid rises within 2 + DEBOUNCE_CNT*SCAN_DIV + 1 cycles.
- Worst case from press to detection adds up to 4*SCAN_DIV cycles of scan delay.

Optional Feature:
- Macro: KEYPAD_OVERRUN_EN.
- When defined:
  - The overrun port exists.
  - Set sticky to 1 the cycle after a new key is dropped, i.e. it latches while key_valid=1 and no key_ack that cycle.
  - Cleared by key_ack (same timing as key_valid), or by reset.
  - An ack and a drop in the same cycle leaves overrun=0.
- When undefined: the port is absent and dropped keys are silently lost.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset asserted mid-DEBOUNCE -> col_out=4'b1110 and key_valid=0 immediately; after release, columns cycle 1110, 1101, 1011, 0111, 1110 every 4 clk.
- Key row2/col1 held steady -> key_valid=1, key_code=4'h9, key_pressed=1. key_ack pulse -> key_valid=0 next cycle, key_code remains 9.
- Key row0/col3 bounces (low 1 tick, high 1 tick) -> no key_valid, scan resumes. Then stable -> key_code=4'h3.
- Rows 1 and 3 both low on col0 -> key_code=4'h4 (lowest row). Release held 3 ticks -> key_pressed=0, scan restarts at col1.
- Key A (code 5) unacked, then key B (code 10) pressed and released -> key_code stays 5, key_valid=1. With KEYPAD_OVERRUN_EN, overrun=1 until key_ack.
- key_ack in the same cycle as the new code latch (code 2) -> key_valid stays 1, key_code=2, overrun=0.
